// File: rtl/ram_1r1w_ctrl.sv
// Valid/ready front end for the ram_1r1w memory model: read/write arbitration,
// read-latency tracking with a 2-entry response FIFO, and write-completion accounting.
module ram_1r1w_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_PARTITIONS = 1,
  parameter int COMP_CNT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     rd_req_addr,
  input  logic [NUM_PARTITIONS-1:0] rd_req_mask,
  input  logic                      rd_req_valid,
  output logic                      rd_req_ready,
  output logic [DATA_WIDTH-1:0]     rd_resp_data,
  output logic                      rd_resp_valid,
  input  logic                      rd_resp_ready,
  input  logic [ADDR_WIDTH-1:0]     wr_req_addr,
  input  logic [DATA_WIDTH-1:0]     wr_req_data,
  input  logic [NUM_PARTITIONS-1:0] wr_req_mask,
  input  logic                      wr_req_valid,
  output logic                      wr_req_ready,
  output logic                      wr_comp_valid,
  input  logic                      wr_comp_ready,
  output logic [ADDR_WIDTH-1:0]     ram_rd_addr,
  output logic [NUM_PARTITIONS-1:0] ram_rd_mask,
  output logic                      ram_rd_en,
  input  logic [DATA_WIDTH-1:0]     ram_rd_data,
  output logic [ADDR_WIDTH-1:0]     ram_wr_addr,
  output logic [DATA_WIDTH-1:0]     ram_wr_data,
  output logic [NUM_PARTITIONS-1:0] ram_wr_mask,
  output logic                      ram_wr_en
);

  // state    | meaning
  // GRANT_WR | last grant went to write (reset value, so read wins the first tie)
  // GRANT_RD | last grant went to read
  typedef enum logic {GRANT_WR, GRANT_RD} grant_t;

  localparam int PART_WIDTH = DATA_WIDTH / NUM_PARTITIONS;
  localparam logic [COMP_CNT_WIDTH-1:0] COMP_MAX = '1;

  grant_t                    last_grant, last_grant_nxt;
  logic                      inflight;
  logic [NUM_PARTITIONS-1:0] inflight_mask;
  logic [DATA_WIDTH-1:0]     fifo_mem [2];
  logic                      fifo_wr_ptr, fifo_rd_ptr;
  logic [1:0]                fifo_count;
  logic [COMP_CNT_WIDTH-1:0] comp_cnt;
  logic                      rd_elig, wr_elig, rd_win, wr_win;
  logic                      push, pop, comp_fire;
  logic [DATA_WIDTH-1:0]     mask_bits;

  // Reads are throttled so the FIFO always has room for every read already issued.
  assign rd_elig = rd_req_valid && (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);
  assign wr_elig = wr_req_valid && (comp_cnt != COMP_MAX);

  always_comb begin
    rd_win         = 1'b0;
    wr_win         = 1'b0;
    last_grant_nxt = last_grant;
    if (rd_elig && (!wr_elig || last_grant == GRANT_WR)) begin
      rd_win         = 1'b1;
      last_grant_nxt = GRANT_RD;
    end else if (wr_elig) begin
      wr_win         = 1'b1;
      last_grant_nxt = GRANT_WR;
    end
  end

  assign rd_req_ready = rd_win;
  assign wr_req_ready = wr_win;
  assign ram_rd_en    = rd_win;
  assign ram_wr_en    = wr_win;
  assign ram_rd_addr  = rd_req_addr;
  assign ram_rd_mask  = rd_req_mask;
  assign ram_wr_addr  = wr_req_addr;
  assign ram_wr_data  = wr_req_data;
  assign ram_wr_mask  = wr_req_mask;

  assign push          = inflight;
  assign rd_resp_valid = (fifo_count != 2'd0);
  assign pop           = rd_resp_valid && rd_resp_ready;
  assign rd_resp_data  = fifo_mem[fifo_rd_ptr];
  assign wr_comp_valid = (comp_cnt != '0);
  assign comp_fire     = wr_comp_valid && wr_comp_ready;

  always_comb begin
    mask_bits = '0;
    for (int p = 0; p < NUM_PARTITIONS; p++)
      mask_bits[p*PART_WIDTH +: PART_WIDTH] = {PART_WIDTH{inflight_mask[p]}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant <= GRANT_WR;
    else      last_grant <= last_grant_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight      <= 1'b0;
      inflight_mask <= '0;
      fifo_mem[0]   <= '0;
      fifo_mem[1]   <= '0;
      fifo_wr_ptr   <= 1'b0;
      fifo_rd_ptr   <= 1'b0;
      fifo_count    <= 2'd0;
      comp_cnt      <= '0;
    end else begin
      inflight <= rd_win;
      if (rd_win) inflight_mask <= rd_req_mask;
      if (push) begin
        fifo_mem[fifo_wr_ptr] <= ram_rd_data & mask_bits;
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
      case ({wr_win, comp_fire})
        2'b10:   comp_cnt <= comp_cnt + COMP_CNT_WIDTH'(1);
        2'b01:   comp_cnt <= comp_cnt - COMP_CNT_WIDTH'(1);
        default: comp_cnt <= comp_cnt;
      endcase
    end
  end

endmodule
